fifo_psram_io_rd_sync: RTL and testbench
========================================

Name: fifo_psram_io_rd_sync

Overview:
- Parametrised single-clock FIFO for the pSRAM read-data path; successor to the fixed 16x18 dual-clock EMB read buffer.
- Adds full/empty flags, programmable almost-full/almost-empty thresholds, a fill level, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the pSRAM IO read capture logic (writer) and the video pixel-unpack stage (reader), both in the pSRAM core clock domain.

Parameters:
- DATA_W, 18, word width in bits; legal range 1..72.
- ADDR_W, 4, log2 of depth (depth = 2^ADDR_W); legal range 2..10.
- FWFT, 0, read mode: 0 = standard (data 1 cycle after rd_en); 1 = first-word-fall-through.
- AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high; clears all state.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of the current word).
- rd_data  out  DATA_W  read word.
- rd_valid  out  1  rd_data holds a valid word.
- full  out  1  no free location.
- empty  out  1  no word available to read.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  ADDR_W+1  words held, 0..2^ADDR_W.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, level=0, overflow=0, underflow=0. Read and write pointers are 0; storage contents are undefined.
- Storage: 2^ADDR_W x DATA_W, one write port and one read port. Read is registered with 1-cycle latency, so it maps to EMB5K sdp with outreg off.
- Pointers: ADDR_W+1 bits each; the extra MSB distinguishes full from empty. full = (MSBs differ && address bits equal). Pointers wrap naturally at 2^ADDR_W.
- Write accept: wr_en && (!full || read accepted in the same cycle). A rejected write leaves the pointer and storage untouched and sets overflow the next cycle.
- Standard mode (FWFT=0):
  - Read accept: rd_en && !empty.
  - rd_data updates and rd_valid pulses 1 cycle after the accept; otherwise rd_valid=0 and rd_data holds its last value.
  - empty deasserts 1 cycle after the first write into an empty FIFO.
- FWFT mode (FWFT=1):
  - A one-word output register is prefetched automatically from RAM.
  - rd_valid=1 while it holds a word; rd_data is stable until it is popped.
  - empty = !rd_valid.
  - Latency from a write into an empty FIFO to rd_valid=1 is 2 cycles.
  - Pop: rd_en && rd_valid. The next word (if any) is presented on the cycle after the pop, with no bubble when the RAM is non-empty. This requires a continuous prefetch read.
  - level and full include the output-register word.
- Underflow: rd_en while empty (FWFT=1: while !rd_valid) is ignored and sets underflow.
- Simultaneous write and read:
  - When full: both are accepted, level is unchanged, full stays 1.
  - When empty (FWFT=0): the write is accepted, the read is rejected and underflow sets.
- level: +1 on an accepted write only, -1 on an accepted read/pop only, unchanged when both or neither occur. It is registered and updates on the same edge as the pointers.
- almost_full, almost_empty and full are registered and derived from the next-state level, so they are valid in the same cycle as level.
- overflow and underflow stay set until err_clr=1 or rst. If err_clr coincides with a new error, the error wins and the flag stays 1.
- Reset mid-operation: all flags and pointers return to their reset values immediately (asynchronously). The first post-reset write behaves as a write into an empty FIFO.
- Parameter check: AF_LEVEL must lie in 1..2^ADDR_W and AE_LEVEL in 0..2^ADDR_W-1, enforced by an elaboration-time check.

Test Plan:
- Reset, then write 0x00001..0x00010 (16 words, DATA_W=18, ADDR_W=4, FWFT=0) -> full=1 at level=16; almost_full rises on the 12th write; a 17th write sets overflow and 0x00010 is not overwritten.
- Read 16 words from full -> rd_data follows 0x00001..0x00010 each 1 cycle after rd_en; empty=1 after the 16th; a 17th rd_en sets underflow; almost_empty rises at level=2.
- Wrap: sustain 40 cycles of simultaneous wr_en/rd_en at level=8 -> level stays 8 and the data order is preserved across 2+ pointer wraps.
- FWFT=1: write 0x2AAAA into an empty FIFO -> rd_valid=1 and rd_data=0x2AAAA 2 cycles later without rd_en; 4 back-to-back pops deliver 4 words with no bubble.
- Full and read+write in the same cycle -> both accepted, level=16, no overflow. Then err_clr=1 with a concurrent write while full -> overflow remains 1.
- Assert rst asynchronously at level=9 mid-burst -> all outputs take their reset values before the next edge; a subsequent write/read round-trip of 0x15555 is correct.

Source files
------------

// File: rtl/fifo_psram_io_rd_sync.sv
// Single-clock pSRAM read-data FIFO: registered-read RAM, level/flag tracking, sticky errors.
// FWFT=0 returns data one cycle after rd_en; FWFT=1 keeps a prefetched word in an output register.
module fifo_psram_io_rd_sync #(
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO    = '0;

  if (DATA_W < 1 || DATA_W > 72 || ADDR_W < 2 || ADDR_W > 10) begin : g_bad_size
    $error("fifo_psram_io_rd_sync: DATA_W or ADDR_W out of range");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
    $error("fifo_psram_io_rd_sync: AF_LEVEL/AE_LEVEL out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] ram_dout_q;
  logic              ram_vld_q, ram_vld_d;
  logic [DATA_W-1:0] out_q;
  logic              out_vld_q, out_vld_d;
  logic              full_q, empty_q, af_q, ae_q;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              ram_empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ram_re;
  logic              out_load;

  assign ram_empty = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    rd_acc    = 1'b0;
    ram_re    = 1'b0;
    out_load  = 1'b0;
    ram_vld_d = ram_vld_q;
    out_vld_d = out_vld_q;

    if (FWFT != 0) begin
      // The RAM output register acts as a second stage so a pop every cycle never starves.
      rd_acc   = rd_en && out_vld_q;
      out_load = ram_vld_q && (!out_vld_q || rd_acc);
      ram_re   = !ram_empty && (!ram_vld_q || out_load);
      if (ram_re) begin
        ram_vld_d = 1'b1;
      end else if (out_load) begin
        ram_vld_d = 1'b0;
      end
      if (out_load) begin
        out_vld_d = 1'b1;
      end else if (rd_acc) begin
        out_vld_d = 1'b0;
      end
    end else begin
      rd_acc    = rd_en && !empty_q;
      ram_re    = rd_acc;
      ram_vld_d = rd_acc;
    end

    wr_acc   = wr_en && (!full_q || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + ONE : rd_ptr_q;

    level_d = level_q;
    if (wr_acc && !rd_acc) begin
      level_d = level_q + ONE;
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - ONE;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    overflow_d  = (wr_en && !wr_acc) || (overflow_q && !err_clr);
    underflow_d = (rd_en && !rd_acc) || (underflow_q && !err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ram_dout_q  <= '0;
      ram_vld_q   <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ram_vld_q   <= ram_vld_d;
      out_vld_q   <= out_vld_d;
      full_q      <= (level_d == DEPTH_L);
      empty_q     <= (level_d == ZERO);
      af_q        <= (level_d >= AF_L);
      ae_q        <= (level_d <= AE_L);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (ram_re) begin
        ram_dout_q <= mem[rd_ptr_q[ADDR_W-1:0]];
      end
      if (out_load) begin
        out_q <= ram_dout_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data      = (FWFT != 0) ? out_q : ram_dout_q;
  assign rd_valid     = (FWFT != 0) ? out_vld_q : ram_vld_q;
  assign empty        = (FWFT != 0) ? !out_vld_q : empty_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_psram_io_rd_sync.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// against queue-based reference models every cycle.
module tb_fifo_psram_io_rd_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, err_clr;
  logic [17:0] wr_data;

  logic [17:0] rd_data0, rd_data1;
  logic        rd_valid0, full0, empty0, af0, ae0, ovf0, udf0;
  logic        rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0]  level0, level1;

  always #5 clk = ~clk;

  fifo_psram_io_rd_sync #(.DATA_W(18), .ADDR_W(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0),
    .overflow(ovf0), .underflow(udf0), .err_clr(err_clr)
  );

  fifo_psram_io_rd_sync #(.DATA_W(18), .ADDR_W(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1),
    .overflow(ovf1), .underflow(udf1), .err_clr(err_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Standard-mode model: words in order, last word returned.
  logic [17:0] q0[$];
  bit          m_ovf0, m_udf0, m_rv0;
  logic [17:0] m_rdd0;

  // FWFT model: every held word with the edge it was written on; the head shows
  // on rd_data once two edges have passed since its write.
  typedef struct {
    logic [17:0] d;
    int          t;
  } ent_t;
  ent_t q1[$];
  bit   m_ovf1, m_udf1;
  int   cyc = 0;

  function automatic bit head_vis1();
    if (q1.size() == 0) return 1'b0;
    return (cyc >= q1[0].t + 2);
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ovf0 = 0; m_udf0 = 0; m_rv0 = 0; m_rdd0 = '0;
    m_ovf1 = 0; m_udf1 = 0;
  endtask

  task automatic check_all(input string ph);
    bit v;
    v = head_vis1();
    chk({ph, ".s.level"}, level0, q0.size());
    chk({ph, ".s.full"}, full0, q0.size() == 16);
    chk({ph, ".s.empty"}, empty0, q0.size() == 0);
    chk({ph, ".s.afull"}, af0, q0.size() >= 12);
    chk({ph, ".s.aempty"}, ae0, q0.size() <= 2);
    chk({ph, ".s.ovf"}, ovf0, m_ovf0);
    chk({ph, ".s.udf"}, udf0, m_udf0);
    chk({ph, ".s.rvalid"}, rd_valid0, m_rv0);
    chk({ph, ".s.rdata"}, rd_data0, m_rdd0);
    chk({ph, ".f.level"}, level1, q1.size());
    chk({ph, ".f.full"}, full1, q1.size() == 16);
    chk({ph, ".f.afull"}, af1, q1.size() >= 12);
    chk({ph, ".f.aempty"}, ae1, q1.size() <= 2);
    chk({ph, ".f.ovf"}, ovf1, m_ovf1);
    chk({ph, ".f.udf"}, udf1, m_udf1);
    chk({ph, ".f.rvalid"}, rd_valid1, v);
    chk({ph, ".f.empty"}, empty1, !v);
    if (v) chk({ph, ".f.rdata"}, rd_data1, q1[0].d);
  endtask

  // One clock cycle: apply inputs, advance both models on the edge, check 1 ns later.
  task automatic step(input string ph, input bit w, input bit r, input bit c, input logic [17:0] d);
    bit ra0, wa0, v1, p1, wa1;
    wr_en = w; rd_en = r; err_clr = c; wr_data = d;
    ra0 = r && (q0.size() > 0);
    wa0 = w && (q0.size() < 16 || ra0);
    v1  = head_vis1();
    p1  = r && v1;
    wa1 = w && (q1.size() < 16 || p1);
    @(posedge clk);
    cyc++;
    m_rv0 = ra0;
    if (ra0) m_rdd0 = q0.pop_front();
    if (wa0) q0.push_back(d);
    m_ovf0 = (w && !wa0) || (m_ovf0 && !c);
    m_udf0 = (r && !ra0) || (m_udf0 && !c);
    if (p1) void'(q1.pop_front());
    if (wa1) q1.push_back('{d: d, t: cyc});
    m_ovf1 = (w && !wa1) || (m_ovf1 && !c);
    m_udf1 = (r && !p1) || (m_udf1 && !c);
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [17:0] d;
    rst = 1'b1; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all("reset");

    // Fill 1..16, then a 17th write that must be dropped.
    for (int i = 1; i <= 17; i++) step("fill", 1, 0, 0, 18'(i));
    // Drain 16, then one read from empty.
    for (int i = 0; i < 17; i++) step("drain", 0, 1, 0, '0);
    step("clr", 0, 0, 1, '0);

    // Level 8 with 40 cycles of simultaneous write and read (several pointer wraps).
    for (int i = 0; i < 8; i++) step("pre8", 1, 0, 0, 18'($urandom));
    for (int i = 0; i < 40; i++) step("wrap", 1, 1, 0, 18'($urandom));

    // Full plus concurrent read/write, then err_clr racing a fresh overflow.
    for (int i = 0; i < 8; i++) step("tofull", 1, 0, 0, 18'($urandom));
    step("fullrw", 1, 1, 0, 18'($urandom));
    step("clrwin", 1, 0, 1, 18'($urandom));
    step("clr2", 0, 0, 1, '0);
    for (int i = 0; i < 16; i++) step("empty", 0, 1, 0, '0);
    step("clr3", 0, 0, 1, '0);

    // Fall-through latency from an empty FIFO, then back-to-back pops.
    step("ft_wr", 1, 0, 0, 18'h2AAAA);
    for (int i = 0; i < 3; i++) step("ft_idle", 0, 0, 0, '0);
    step("ft_pop", 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step("ft_w4", 1, 0, 0, 18'($urandom));
    for (int i = 0; i < 2; i++) step("ft_idle2", 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step("ft_b2b", 0, 1, 0, '0);

    // Asynchronous reset in the middle of a write burst at level 9.
    for (int i = 0; i < 9; i++) step("pre9", 1, 0, 0, 18'($urandom));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 18'h3FFFF;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("arst");
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    cyc++;
    #2 rst = 1'b0;
    step("rt_wr", 1, 0, 0, 18'h15555);
    step("rt_idle", 0, 0, 0, '0);
    step("rt_rd", 0, 1, 0, '0);
    step("rt_idle2", 0, 0, 0, '0);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 50; i++) begin
        d = 18'($urandom);
        if (ph[0] == 1'b0)
          step("rnd", $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, d);
        else
          step("rnd", $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
